// File: rtl/memb_store.sv
// memb_store: writes the per-cycle DataInB result word sequentially into memory B,
// with a registered readback port. Define MEMB_CHECKSUM_EN to enable the running checksum.
module memb_store #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] DataInB,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // in_valid alongside start only launches the transfer; nothing is stored
        if (start) begin
          wr_addr_d = '0;
          state_d   = StFill;
        end
      end
      StFill: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (wr_addr_q == LastAddr) begin
            wr_addr_d = '0;
            state_d   = StDone;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_addr} < DepthExt) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      wr_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is deliberately not reset so an aborted transfer keeps its words.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr_q] <= DataInB;
    end
  end

`ifdef MEMB_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              clear;

  always_comb begin
    clear      = (state_q == StIdle) && start;
    checksum_d = checksum_q;
    if (clear) begin
      checksum_d = '0;
    end else if (wr_en) begin
      checksum_d = checksum_q + DataInB;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign rd_data = rd_data_q;
  assign wr_addr = wr_addr_q;
  assign busy    = (state_q == StFill);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_memb_store.sv
// Self-checking bench for memb_store: randomized fills checked against an address-indexed
// reference of memory B, transfer-length arithmetic and a modular checksum.
module tb_memb_store;
  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset_n, start, in_valid;
  logic [DW-1:0] DataInB;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, checksum;
  logic [AW-1:0] wr_addr;
  logic          busy, done;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] ref_mem   [DP];
  logic [DW-1:0] stim_data [DP];
  logic [DW-1:0] rb_data   [DP];
  logic [AW-1:0] wr_trace  [DP];
  int            f_busy_cnt, f_done_at, f_done_cnt, f_stalls;
  logic [AW-1:0] f_wr_end;

  memb_store #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .DataInB(DataInB), .rd_addr(rd_addr), .rd_data(rd_data), .wr_addr(wr_addr),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [DW-1:0] exp_checksum();
    int s = 0;
    for (int i = 0; i < DP; i++) s += int'(stim_data[i]);
`ifdef MEMB_CHECKSUM_EN
    return DW'(s % 256);
`else
    return DW'(s * 0);
`endif
  endfunction

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic read_all();
    for (int i = 0; i < DP; i++) begin
      rd_addr = AW'(i);
      cycle();
      rb_data[i] = rd_data;
    end
  endtask

  // mode 0: no stalls, 1: stall every third cycle, 2: random stalls
  task automatic run_fill(input int mode);
    int k = 0;
    int t = 0;
    bit stall;
    start = 1'b1; in_valid = 1'b1; DataInB = DW'($urandom);
    cycle();
    start = 1'b0;
    f_busy_cnt = 0; f_done_at = -1; f_done_cnt = 0; f_stalls = 0;
    while (k < DP && t < 200) begin
      stall = (mode == 1) ? (t % 3 == 2) : (mode == 2) ? ($urandom_range(3) == 0) : 1'b0;
      if (busy) f_busy_cnt++;
      if (stall) begin
        in_valid = 1'b0; DataInB = DW'($urandom); f_stalls++;
      end else begin
        wr_trace[k] = wr_addr;
        in_valid = 1'b1; DataInB = stim_data[k]; k++;
      end
      cycle();
      t++;
    end
    for (int j = 0; j < 4; j++) begin
      if (j == 0) f_wr_end = wr_addr;
      if (done) begin
        f_done_cnt++;
        if (f_done_at < 0) f_done_at = t + j;
      end
      if (busy) f_busy_cnt++;
      in_valid = 1'b1; DataInB = DW'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < DP; i++) ref_mem[i] = stim_data[i];
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; DataInB = '0; rd_addr = '0;
    #1;
    checks++; if (rd_data !== 8'h00) begin failures++;
      $display("FAIL por_rd_data: got %0h want 0", rd_data); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++;
      $display("FAIL por_busy_done: got %b%b want 00", busy, done); end
    @(negedge clock);
    reset_n = 1'b1;
    cycle();
    start = 1'b1; cycle(); start = 1'b0;
    in_valid = 1'b1;
    DataInB = 8'hA5; cycle();
    DataInB = 8'h3C; cycle();
    DataInB = 8'h7E; cycle();
    in_valid = 1'b0; rd_addr = 4'd1;
    cycle();
    checks++; if (rd_data !== 8'h3C || busy !== 1'b1 || wr_addr !== 4'd3) begin failures++;
      $display("FAIL pre_reset: got rd=%0h busy=%b wa=%0d want 3c 1 3", rd_data, busy, wr_addr); end
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (rd_data !== 8'h00) begin failures++;
      $display("FAIL reset_rd_data: got %0h want 0", rd_data); end
    checks++; if (wr_addr !== 4'd0) begin failures++;
      $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++;
      $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    checks++; if (checksum !== 8'h00) begin failures++;
      $display("FAIL reset_checksum: got %0h want 0", checksum); end
    @(negedge clock);
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic test_full_fill();
    logic [DW-1:0] exp_ck;
`ifdef MEMB_CHECKSUM_EN
    exp_ck = 8'h68;
`else
    exp_ck = 8'h00;
`endif
    for (int i = 0; i < DP; i++) stim_data[i] = DW'(3 * i);
    run_fill(0);
    checks++; if (f_busy_cnt !== 16) begin failures++;
      $display("FAIL full_busy_cycles: got %0d want 16", f_busy_cnt); end
    checks++; if (f_done_at !== 16 || f_done_cnt !== 1) begin failures++;
      $display("FAIL full_done: got at=%0d n=%0d want 16 1", f_done_at, f_done_cnt); end
    checks++; if (f_wr_end !== 4'd0) begin failures++;
      $display("FAIL full_wr_wrap: got %0d want 0", f_wr_end); end
    for (int i = 0; i < DP; i++) begin
      checks++; if (wr_trace[i] !== AW'(i)) begin failures++;
        $display("FAIL full_wr_addr[%0d]: got %0d want %0d", i, wr_trace[i], i); end
    end
    checks++; if (checksum !== exp_ck) begin failures++;
      $display("FAIL full_checksum: got %0h want %0h", checksum, exp_ck); end
    rd_addr = 4'd5;
    cycle();
    checks++; if (rd_data !== 8'd15) begin failures++;
      $display("FAIL full_read5: got %0d want 15", rd_data); end
    read_all();
    for (int i = 0; i < DP; i++) begin
      checks++; if (rb_data[i] !== ref_mem[i]) begin failures++;
        $display("FAIL full_mem[%0d]: got %0h want %0h", i, rb_data[i], ref_mem[i]); end
    end
    checks++; if (checksum !== exp_ck) begin failures++;
      $display("FAIL full_checksum_hold: got %0h want %0h", checksum, exp_ck); end
  endtask

  task automatic test_stalls();
    for (int m = 1; m <= 2; m++) begin
      for (int i = 0; i < DP; i++) stim_data[i] = (m == 1) ? DW'(3 * i) : DW'($urandom);
      run_fill(m);
      if (m == 1) begin
        checks++; if (f_stalls !== 7) begin failures++;
          $display("FAIL stall_count: got %0d want 7", f_stalls); end
      end
      checks++; if (f_done_at !== 16 + f_stalls || f_done_cnt !== 1) begin failures++;
        $display("FAIL stall_done[%0d]: got at=%0d n=%0d want %0d 1", m, f_done_at, f_done_cnt,
                 16 + f_stalls); end
      checks++; if (f_busy_cnt !== 16 + f_stalls) begin failures++;
        $display("FAIL stall_busy[%0d]: got %0d want %0d", m, f_busy_cnt, 16 + f_stalls); end
      checks++; if (checksum !== exp_checksum()) begin failures++;
        $display("FAIL stall_checksum[%0d]: got %0h want %0h", m, checksum, exp_checksum()); end
      read_all();
      for (int i = 0; i < DP; i++) begin
        checks++; if (rb_data[i] !== ref_mem[i]) begin failures++;
          $display("FAIL stall_mem[%0d][%0d]: got %0h want %0h", m, i, rb_data[i], ref_mem[i]);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int n_done = 0;
    int at = -1;
    for (int i = 0; i < DP; i++) stim_data[i] = DW'($urandom);
    start = 1'b1; in_valid = 1'b0; cycle(); start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1; DataInB = stim_data[k]; cycle();
    end
    checks++; if (wr_addr !== 4'd7) begin failures++;
      $display("FAIL sb_wr_addr7: got %0d want 7", wr_addr); end
    start = 1'b1; in_valid = 1'b1; DataInB = stim_data[7]; cycle(); start = 1'b0;
    checks++; if (wr_addr !== 4'd8 || busy !== 1'b1) begin failures++;
      $display("FAIL sb_continue: got wa=%0d busy=%b want 8 1", wr_addr, busy); end
    for (int k = 8; k < DP; k++) begin
      if (done) n_done++;
      DataInB = stim_data[k]; cycle();
    end
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (done) begin n_done++; if (at < 0) at = j; end
      cycle();
    end
    checks++; if (n_done !== 1 || at !== 0) begin failures++;
      $display("FAIL sb_done: got n=%0d at=%0d want 1 0", n_done, at); end
    for (int i = 0; i < DP; i++) ref_mem[i] = stim_data[i];
    checks++; if (checksum !== exp_checksum()) begin failures++;
      $display("FAIL sb_checksum: got %0h want %0h", checksum, exp_checksum()); end
    read_all();
    for (int i = 0; i < DP; i++) begin
      checks++; if (rb_data[i] !== ref_mem[i]) begin failures++;
        $display("FAIL sb_mem[%0d]: got %0h want %0h", i, rb_data[i], ref_mem[i]); end
    end
  endtask

  task automatic test_reset_mid_fill();
    int n_done = 0;
    for (int i = 0; i < DP; i++) stim_data[i] = DW'($urandom);
    start = 1'b1; in_valid = 1'b0; cycle(); start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1; DataInB = stim_data[k]; cycle();
    end
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || wr_addr !== 4'd0) begin failures++;
      $display("FAIL mid_reset: got busy=%b done=%b wa=%0d want 0 0 0", busy, done, wr_addr); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 9; k++) ref_mem[k] = stim_data[k];
    for (int j = 0; j < 4; j++) begin
      if (done || busy) n_done++;
      in_valid = 1'b1; DataInB = DW'($urandom); cycle();
    end
    in_valid = 1'b0;
    checks++; if (n_done !== 0) begin failures++;
      $display("FAIL mid_idle: got %0d active cycles want 0", n_done); end
    read_all();
    for (int i = 0; i < DP; i++) begin
      checks++; if (rb_data[i] !== ref_mem[i]) begin failures++;
        $display("FAIL mid_mem[%0d]: got %0h want %0h", i, rb_data[i], ref_mem[i]); end
    end
    for (int i = 0; i < DP; i++) stim_data[i] = DW'($urandom);
    run_fill(0);
    checks++; if (wr_trace[0] !== 4'd0 || f_done_at !== 16 || f_done_cnt !== 1) begin
      failures++;
      $display("FAIL mid_refill: got wa0=%0d at=%0d n=%0d want 0 16 1", wr_trace[0], f_done_at,
               f_done_cnt); end
    read_all();
    for (int i = 0; i < DP; i++) begin
      checks++; if (rb_data[i] !== ref_mem[i]) begin failures++;
        $display("FAIL refill_mem[%0d]: got %0h want %0h", i, rb_data[i], ref_mem[i]); end
    end
  endtask

  task automatic test_collision();
    for (int i = 0; i < DP; i++) stim_data[i] = DW'($urandom);
    stim_data[4] = 8'hAA;
    run_fill(0);
    for (int i = 0; i < DP; i++) stim_data[i] = DW'($urandom);
    stim_data[4] = 8'h55;
    rd_addr = 4'd4;
    start = 1'b1; in_valid = 1'b0; cycle(); start = 1'b0;
    for (int k = 0; k < DP; k++) begin
      in_valid = 1'b1; DataInB = stim_data[k]; cycle();
      if (k == 4) begin
        checks++; if (rd_data !== 8'hAA) begin failures++;
          $display("FAIL coll_old: got %0h want aa", rd_data); end
      end
      if (k == 5) begin
        checks++; if (rd_data !== 8'h55) begin failures++;
          $display("FAIL coll_new: got %0h want 55", rd_data); end
      end
    end
    in_valid = 1'b0;
    checks++; if (done !== 1'b1) begin failures++;
      $display("FAIL coll_done: got %b want 1", done); end
    cycle();
    for (int i = 0; i < DP; i++) ref_mem[i] = stim_data[i];
    checks++; if (checksum !== exp_checksum()) begin failures++;
      $display("FAIL coll_checksum: got %0h want %0h", checksum, exp_checksum()); end
  endtask

  initial begin
    test_reset();
    test_full_fill();
    test_stalls();
    test_start_while_busy();
    test_reset_mid_fill();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
